// File: rtl/sync_lock_pkg.sv
// Shared types and small helpers for the camera-lock supervisor.
package sync_lock_pkg;

    typedef enum logic [2:0] {IDLE, ARM, ACQUIRE, TRACK, LOST} lock_state_t;
    typedef enum logic [1:0] {V_NONE, V_GOOD, V_BAD} verdict_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_line_judge.sv
// Per-line alignment judge: compares camera href rises with generator
// data_en rises and emits one GOOD/BAD verdict per generator rise.
module sync_line_judge
    import sync_lock_pkg::*;
#(
    parameter int TOL = 4
)
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     i_clr,
    input  logic     i_cam_href,
    input  logic     i_gen_de,
    output verdict_t o_verdict
);

    localparam int            SW   = $clog2(TOL + 2);
    localparam logic [SW-1:0] SAT  = SW'(TOL + 1);
    localparam logic [SW-1:0] TOLV = SW'(TOL);
    localparam logic [SW-1:0] ONE  = SW'(1);

    logic          r_cam_d;
    logic          r_gen_d;
    logic [SW-1:0] r_since_cam;
    logic [SW-1:0] r_since_gen;
    logic          r_pend;

    logic w_cam_rise;
    logic w_gen_rise;
    logic w_cam_near;

    // The delayed copies reset high so a level already high after reset is not an edge.
    assign w_cam_rise = i_cam_href & ~r_cam_d;
    assign w_gen_rise = i_gen_de & ~r_gen_d;
    // A cam rise in this very cycle counts as distance 0.
    assign w_cam_near = w_cam_rise | (r_since_cam <= TOLV);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == SAT) ? SAT : v + ONE;
    endfunction

    // Edge history, distance counters, late-cam window and the registered verdict.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cam_d     <= 1'b1;
            r_gen_d     <= 1'b1;
            r_since_cam <= '0;
            r_since_gen <= '0;
            r_pend      <= 1'b0;
            o_verdict   <= V_NONE;
        end else begin
            r_cam_d <= i_cam_href;
            r_gen_d <= i_gen_de;
            if (i_clr) begin
                r_since_cam <= SAT;
                r_since_gen <= SAT;
                r_pend      <= 1'b0;
                o_verdict   <= V_NONE;
            end else begin
                // Counters read 1 on the cycle after a rise, i.e. the distance in cycles.
                r_since_cam <= w_cam_rise ? ONE : sat_inc(r_since_cam);
                r_since_gen <= w_gen_rise ? ONE : sat_inc(r_since_gen);
                o_verdict   <= V_NONE;
                if (w_gen_rise) begin
                    // A new gen rise supersedes any window still open from an earlier one.
                    if (w_cam_near) begin
                        o_verdict <= V_GOOD;
                        r_pend    <= 1'b0;
                    end else begin
                        r_pend    <= 1'b1;
                    end
                end else if (r_pend) begin
                    if (w_cam_rise) begin
                        o_verdict <= V_GOOD;
                        r_pend    <= 1'b0;
                    end else if (r_since_gen == TOLV) begin
                        o_verdict <= V_BAD;
                        r_pend    <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sync_lock_ctrl.sv
// Supervisor for the camera-locked timing generator: owns the generator
// reset, acquires lock from per-line verdicts, and re-arms on loss of lock.
module sync_lock_ctrl
    import sync_lock_pkg::*;
#(
    parameter int RST_CYC     = 16,
    parameter int ACQ_TIMEOUT = 2000000,
    parameter int TOL         = 4,
    parameter int MAX_BAD     = 8,
    parameter int GOOD_LINES  = 16
)
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_enable,
    input  logic       i_cam_href,
    input  logic       i_gen_de,
    output logic       o_gen_rstn,
    output logic       o_locked,
    output logic       o_acq_fail,
    output logic       o_lock_lost,
    output logic [7:0] o_relock_cnt
);

    localparam int CNT_MAX = (ACQ_TIMEOUT > RST_CYC) ? ACQ_TIMEOUT : RST_CYC;
    localparam int CW      = cnt_w(CNT_MAX);
    localparam int GW      = cnt_w(GOOD_LINES);
    localparam int BW      = cnt_w(MAX_BAD);

    localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
    localparam logic [CW-1:0] ARM_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] ACQ_LAST = CW'(ACQ_TIMEOUT - 1);
    localparam logic [GW-1:0] GOOD_LST = GW'(GOOD_LINES - 1);
    localparam logic [BW-1:0] BAD_LST  = BW'(MAX_BAD - 1);

    lock_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_good;
    logic [BW-1:0] r_bad;
    logic          r_gen_seen;

    verdict_t      w_verdict;
    logic          w_clr;

    // The judge only runs while the generator is out of reset.
    assign w_clr = (r_state == IDLE) || (r_state == ARM) || (r_state == LOST);

    sync_line_judge #(
        .TOL (TOL)
    ) u_judge (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_clr),
        .i_cam_href (i_cam_href),
        .i_gen_de   (i_gen_de),
        .o_verdict  (w_verdict)
    );

    // Lock FSM with its counters and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_good       <= '0;
            r_bad        <= '0;
            r_gen_seen   <= 1'b0;
            o_gen_rstn   <= 1'b0;
            o_locked     <= 1'b0;
            o_acq_fail   <= 1'b0;
            o_lock_lost  <= 1'b0;
            o_relock_cnt <= '0;
        end else begin
            o_acq_fail  <= 1'b0;
            o_lock_lost <= 1'b0;
            if (!i_enable) begin
                // Disable wins from any state; the relock history is kept.
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_good     <= '0;
                r_bad      <= '0;
                r_gen_seen <= 1'b0;
                o_gen_rstn <= 1'b0;
                o_locked   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ARM;
                        r_cnt   <= '0;
                    end
                    ARM: begin
                        if (r_cnt == ARM_LAST) begin
                            r_state    <= ACQUIRE;
                            r_cnt      <= '0;
                            r_good     <= '0;
                            r_gen_seen <= 1'b0;
                            o_gen_rstn <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ACQUIRE: begin
                        // Saturate so a generator that runs but never aligns cannot wrap the timer.
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (w_verdict != V_NONE) begin
                            r_gen_seen <= 1'b1;
                        end
                        if (w_verdict == V_GOOD) begin
                            if (r_good == GOOD_LST) begin
                                r_state  <= TRACK;
                                r_bad    <= '0;
                                o_locked <= 1'b1;
                            end else begin
                                r_good <= r_good + GW'(1);
                            end
                        end else if (w_verdict == V_BAD) begin
                            r_good <= '0;
                        end else if (!r_gen_seen && (r_cnt == ACQ_LAST)) begin
                            r_state      <= LOST;
                            o_acq_fail   <= 1'b1;
                            o_gen_rstn   <= 1'b0;
                            o_relock_cnt <= sat_inc8(o_relock_cnt);
                        end
                    end
                    TRACK: begin
                        if (w_verdict == V_GOOD) begin
                            r_bad <= '0;
                        end else if (w_verdict == V_BAD) begin
                            if (r_bad == BAD_LST) begin
                                r_state      <= LOST;
                                o_lock_lost  <= 1'b1;
                                o_locked     <= 1'b0;
                                o_gen_rstn   <= 1'b0;
                                o_relock_cnt <= sat_inc8(o_relock_cnt);
                            end else begin
                                r_bad <= r_bad + BW'(1);
                            end
                        end
                    end
                    LOST: begin
                        r_state <= ARM;
                        r_cnt   <= '0;
                    end
                    default: begin
                        r_state    <= IDLE;
                        o_gen_rstn <= 1'b0;
                        o_locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_lock_ctrl.sv
// Bench for sync_lock_ctrl: line stimulus with a verdict scoreboard,
// a distance table, and hand sequences for arm/lock/loss/timeout/disable.
module tb_sync_lock_ctrl;
    import sync_lock_pkg::*;

    localparam int RST_CYC     = 16;
    localparam int ACQ_TIMEOUT = 100;
    localparam int TOL         = 4;
    localparam int MAX_BAD     = 8;
    localparam int GOOD_LINES  = 16;
    localparam int PW          = 8;

    logic       clk        = 1'b0;
    logic       rstn       = 1'b0;
    logic       i_enable   = 1'b0;
    logic       i_cam_href = 1'b0;
    logic       i_gen_de   = 1'b0;
    logic       o_gen_rstn;
    logic       o_locked;
    logic       o_acq_fail;
    logic       o_lock_lost;
    logic [7:0] o_relock_cnt;

    typedef struct { verdict_t v; int at; } exp_t;
    typedef struct { int ca; int ga; verdict_t v; } vec_t;

    exp_t sb_q[$];
    int   lock_q[$];
    int   lost_q[$];
    int   acq_q[$];
    int   grise_q[$];
    int   relock_at_lost_q[$];
    int   locked_at_lost_q[$];
    int   relock_at_acq_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic p_locked = 1'b0;
    logic p_grstn  = 1'b0;

    vec_t tbl[12];

    always #5 clk = ~clk;

    sync_lock_ctrl #(
        .RST_CYC     (RST_CYC),
        .ACQ_TIMEOUT (ACQ_TIMEOUT),
        .TOL         (TOL),
        .MAX_BAD     (MAX_BAD),
        .GOOD_LINES  (GOOD_LINES)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_enable     (i_enable),
        .i_cam_href   (i_cam_href),
        .i_gen_de     (i_gen_de),
        .o_gen_rstn   (o_gen_rstn),
        .o_locked     (o_locked),
        .o_acq_fail   (o_acq_fail),
        .o_lock_lost  (o_lock_lost),
        .o_relock_cnt (o_relock_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle at which the verdict for a gen rise driven at cycle g must appear.
    function automatic int exp_at(input int ca, input int ga, input verdict_t v, input int g);
        int d;
        d = ca - ga;
        if (v == V_GOOD) return g + 1 + ((d > 0) ? d : 0);
        return g + TOL + 1;
    endfunction

    // One line: cam pulse at ca (none if ca<0), gen pulse at ga; pushes the expected verdict.
    task automatic drive_line(input int ca, input int ga, input int period, input verdict_t v, output int gat);
        exp_t x;
        gat = -1;
        for (int t = 0; t < period; t++) begin
            i_cam_href = (ca >= 0) && (t >= ca) && (t < ca + PW);
            i_gen_de   = (t >= ga) && (t < ga + PW);
            if (t == ga) begin
                gat  = cyc;
                x.v  = v;
                x.at = exp_at(ca, ga, v, cyc);
                sb_q.push_back(x);
            end
            tick();
        end
        i_cam_href = 1'b0;
        i_gen_de   = 1'b0;
    endtask

    // Scoreboard for judge verdicts and recorder of status-output events.
    always @(negedge clk) begin
        if (dut.u_judge.o_verdict != V_NONE) begin
            if (sb_q.size() == 0) begin
                chk("verdict_unexpected", int'(dut.u_judge.o_verdict), int'(V_NONE));
            end else begin
                chk("verdict_value", int'(dut.u_judge.o_verdict), int'(sb_q[0].v));
                chk("verdict_cycle", cyc, sb_q[0].at);
                sb_q.delete(0);
            end
        end
        if (o_locked && !p_locked) lock_q.push_back(cyc);
        if (o_lock_lost) begin
            lost_q.push_back(cyc);
            relock_at_lost_q.push_back(int'(o_relock_cnt));
            locked_at_lost_q.push_back(int'(o_locked));
        end
        if (o_acq_fail) begin
            acq_q.push_back(cyc);
            relock_at_acq_q.push_back(int'(o_relock_cnt));
        end
        if (o_gen_rstn && !p_grstn) grise_q.push_back(cyc);
        p_locked <= o_locked;
        p_grstn  <= o_gen_rstn;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int e;
        int n0;
        int ref_cyc;

        // distance table: cam offset, gen offset, required verdict
        tbl[0]  = '{5,  5, V_GOOD};   // same cycle
        tbl[1]  = '{9,  5, V_GOOD};   // cam 4 after gen
        tbl[2]  = '{10, 5, V_BAD};    // cam 5 after gen
        tbl[3]  = '{3,  5, V_GOOD};   // cam 2 before gen
        tbl[4]  = '{1,  5, V_GOOD};   // cam 4 before gen
        tbl[5]  = '{0,  5, V_BAD};    // cam 5 before gen
        tbl[6]  = '{6,  5, V_GOOD};   // cam 1 after gen
        tbl[7]  = '{15, 5, V_BAD};    // cam 10 after gen
        tbl[8]  = '{-1, 5, V_BAD};    // no cam at all
        tbl[9]  = '{8,  5, V_GOOD};   // cam 3 after gen
        tbl[10] = '{4,  5, V_GOOD};   // cam 1 before gen
        tbl[11] = '{2,  5, V_GOOD};   // cam 3 before gen

        // reset state
        repeat (3) tick();
        chk("rst_gen_rstn",   int'(o_gen_rstn),   0);
        chk("rst_locked",     int'(o_locked),     0);
        chk("rst_acq_fail",   int'(o_acq_fail),   0);
        chk("rst_lock_lost",  int'(o_lock_lost),  0);
        chk("rst_relock_cnt", int'(o_relock_cnt), 0);
        rstn = 1'b1;
        tick();
        chk("idle_gen_rstn", int'(o_gen_rstn), 0);

        // enable: generator held in reset for the arm period, then released
        n0 = grise_q.size();
        e  = cyc;
        i_enable = 1'b1;
        for (int i = 0; i < 40 && grise_q.size() <= n0; i++) tick();
        chk("arm_release_cycle", (grise_q.size() > n0) ? grise_q[n0] : -1, e + RST_CYC + 1);
        chk("arm_locked", int'(o_locked), 0);
        chk("arm_relock_cnt", int'(o_relock_cnt), 0);

        // acquire: gen 2 cycles after cam, long lines
        for (int i = 0; i < GOOD_LINES; i++) drive_line(0, 2, 1660, V_GOOD, g);
        chk("lock_cycle", (lock_q.size() > 0) ? lock_q[0] : -1, g + 2);
        chk("locked_high", int'(o_locked), 1);

        // cam shifted +10: bad lines until lock is lost, then re-arm
        n0 = grise_q.size();
        for (int i = 0; i < MAX_BAD; i++)
            drive_line(10, 2, (i == MAX_BAD - 1) ? 20 : 1660, V_BAD, g);
        ref_cyc = g + TOL + 2;
        chk("lost_cycle", (lost_q.size() > 0) ? lost_q[0] : -1, ref_cyc);
        chk("lost_relock_cnt", (relock_at_lost_q.size() > 0) ? relock_at_lost_q[0] : -1, 1);
        chk("lost_locked", (locked_at_lost_q.size() > 0) ? locked_at_lost_q[0] : -1, 0);
        for (int i = 0; i < 40 && grise_q.size() <= n0; i++) tick();
        chk("rearm_release_cycle", (grise_q.size() > n0) ? grise_q[n0] : -1, ref_cyc + RST_CYC + 1);

        // asynchronous reset mid-acquire, checked before any clock edge
        repeat (5) tick();
        #2 rstn = 1'b0;
        #1;
        chk("async_gen_rstn",   int'(o_gen_rstn),   0);
        chk("async_locked",     int'(o_locked),     0);
        chk("async_relock_cnt", int'(o_relock_cnt), 0);
        tick();
        rstn = 1'b1;
        n0 = grise_q.size();
        e  = cyc;
        for (int i = 0; i < 40 && grise_q.size() <= n0; i++) tick();
        ref_cyc = (grise_q.size() > n0) ? grise_q[n0] : -1;
        chk("post_reset_release_cycle", ref_cyc, e + RST_CYC + 1);

        // acquire timeout with gen_de held low
        n0 = acq_q.size();
        for (int i = 0; i < ACQ_TIMEOUT + 50 && acq_q.size() <= n0; i++) tick();
        chk("acq_fail_cycle", (acq_q.size() > n0) ? acq_q[n0] : -1, ref_cyc + ACQ_TIMEOUT);
        chk("acq_relock_cnt", (relock_at_acq_q.size() > n0) ? relock_at_acq_q[n0] : -1, 1);
        ref_cyc = ref_cyc + ACQ_TIMEOUT;
        n0 = grise_q.size();
        for (int i = 0; i < 40 && grise_q.size() <= n0; i++) tick();
        chk("timeout_rearm_cycle", (grise_q.size() > n0) ? grise_q[n0] : -1, ref_cyc + RST_CYC + 1);

        // distance table through the judge
        for (int i = 0; i < 12; i++) drive_line(tbl[i].ca, tbl[i].ga, 40, tbl[i].v, g);

        // lock again, then drop enable mid-track
        for (int i = 0; i < GOOD_LINES; i++) drive_line(0, 2, 40, V_GOOD, g);
        chk("relock_locked", int'(o_locked), 1);
        i_enable = 1'b0;
        tick();
        chk("disable_locked",     int'(o_locked),     0);
        chk("disable_gen_rstn",   int'(o_gen_rstn),   0);
        chk("disable_relock_cnt", int'(o_relock_cnt), 1);
        repeat (3) tick();
        chk("disabled_gen_rstn", int'(o_gen_rstn), 0);
        n0 = grise_q.size();
        e  = cyc;
        i_enable = 1'b1;
        for (int i = 0; i < 40 && grise_q.size() <= n0; i++) tick();
        chk("reenable_release_cycle", (grise_q.size() > n0) ? grise_q[n0] : -1, e + RST_CYC + 1);

        repeat (10) tick();
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("lock_lost_pulses", lost_q.size(), 1);
        chk("acq_fail_pulses", acq_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
